// File: rtl/led_pwm_fader_if.sv
// Bundles the pattern-generator-facing signals of the LED PWM fader.
// The master side (pattern generator) drives the pattern and the
// brightness. The slave side (the fader) returns the LED drive and busy.
interface led_pwm_fader_if #(
    parameter int PWM_BITS = 8
);
    logic [3:0]          led_in;
    logic [PWM_BITS-1:0] bright_max;
    logic [3:0]          led_out;
    logic                busy;

    modport master (
        output led_in,
        output bright_max,
        input  led_out,
        input  busy
    );

    modport slave (
        input  led_in,
        input  bright_max,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_pwm_fader.sv
// LED PWM fader. Each of the four channels ramps its brightness level
// linearly toward its target, one STEP per fade tick. The level is then
// turned into a PWM waveform by comparing it with a shared free-running
// counter.

// One fader channel: level ramp plus registered PWM compare.
module led_pwm_lane #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                osc_clk,
    input  logic                gsrn,
    input  logic                tick,
    input  logic                on,
    input  logic [PWM_BITS-1:0] bright,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                busy
);
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP);

    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                pwm_q, pwm_d;
    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS:0]   diff;

    // Next level: step toward the target on a tick, and clamp at the target.
    // The extra top bit catches overflow on a rise and borrow on a fall, so
    // the level never wraps.
    always_comb begin
        tgt     = on ? bright : '0;
        sum     = {1'b0, level_q} + STEP_W;
        diff    = {1'b0, level_q} - STEP_W;
        level_d = level_q;
        pwm_d   = (pwm_cnt < level_q);
        if (tick) begin
            if (level_q < tgt) begin
                level_d = (sum > {1'b0, tgt}) ? tgt : sum[PWM_BITS-1:0];
            end else if (level_q > tgt) begin
                level_d = (diff[PWM_BITS] || (diff[PWM_BITS-1:0] < tgt))
                          ? tgt : diff[PWM_BITS-1:0];
            end
        end
    end

    // Level and PWM output registers.
    always_ff @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign led_out = pwm_q;
    assign busy    = (level_q != tgt);
endmodule

module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 450000,
    parameter int STEP     = 1
) (
    input  logic              osc_clk,
    input  logic              gsrn,
    led_pwm_fader_if.slave    bus
);
    localparam int NUM_LANES = 4;
    localparam int PW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(FADE_DIV - 1);

    logic [NUM_LANES-1:0] led_q, led_d;
    logic [PWM_BITS-1:0]  bright_q, bright_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic                 tick;
    logic [NUM_LANES-1:0] lane_out;
    logic [NUM_LANES-1:0] lane_busy;

    // Input capture, fade prescaler, and the free-running PWM counter.
    // The PWM counter wraps naturally at its width.
    always_comb begin
        led_d     = bus.led_in;
        bright_d  = bus.bright_max;
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // Shared state registers.
    always_ff @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
            led_q     <= '0;
            bright_q  <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            led_q     <= led_d;
            bright_q  <= bright_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        led_pwm_lane #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_lane (
            .osc_clk (osc_clk),
            .gsrn    (gsrn),
            .tick    (tick),
            .on      (led_q[i]),
            .bright  (bright_q),
            .pwm_cnt (pwm_cnt_q),
            .led_out (lane_out[i]),
            .busy    (lane_busy[i])
        );
    end

    assign bus.led_out = lane_out;
    assign bus.busy    = |lane_busy;
endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader (PWM_BITS=4, FADE_DIV=4, STEP=3).
// An arithmetic reference model tracks cycle count, the registered inputs,
// and the channel levels. A compare process checks led_out and busy on every
// falling edge. Literal expectations pin the model's level sequences and
// the observable duty cycles.
module tb_led_pwm_fader;
    localparam int PB = 4;
    localparam int FD = 4;
    localparam int ST = 3;
    localparam int PERIOD = 1 << PB;

    logic osc_clk = 1'b0;
    logic gsrn    = 1'b1;

    led_pwm_fader_if #(.PWM_BITS(PB)) bus ();

    led_pwm_fader #(.PWM_BITS(PB), .FADE_DIV(FD), .STEP(ST)) dut (
        .osc_clk (osc_clk),
        .gsrn    (gsrn),
        .bus     (bus)
    );

    always #5 osc_clk = ~osc_clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state.
    int m_cyc = 0;
    int m_led = 0;
    int m_bright = 0;
    int m_level[4] = '{0, 0, 0, 0};
    int m_out[4] = '{0, 0, 0, 0};
    int lvl0_q[$];

    function automatic int m_tgt(input int i);
        return ((m_led >> i) & 1) ? m_bright : 0;
    endfunction

    function automatic int m_busy();
        int b;
        b = 0;
        for (int i = 0; i < 4; i++) if (m_level[i] != m_tgt(i)) b = 1;
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the cycle index gives the PWM phase and the tick. Levels move
    // by STEP toward the target and are clamped with min and max.
    always @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
            m_cyc = 0; m_led = 0; m_bright = 0;
            for (int i = 0; i < 4; i++) begin m_level[i] = 0; m_out[i] = 0; end
        end else begin
            int pwm, old0, t;
            bit tk;
            pwm  = m_cyc % PERIOD;
            tk   = ((m_cyc % FD) == FD - 1);
            old0 = m_level[0];
            for (int i = 0; i < 4; i++) m_out[i] = (pwm < m_level[i]) ? 1 : 0;
            if (tk) begin
                for (int i = 0; i < 4; i++) begin
                    t = m_tgt(i);
                    if (m_level[i] < t)
                        m_level[i] = (m_level[i] + ST > t) ? t : m_level[i] + ST;
                    else if (m_level[i] > t)
                        m_level[i] = (m_level[i] - ST < t) ? t : m_level[i] - ST;
                end
                if (m_level[0] != old0) lvl0_q.push_back(m_level[0]);
            end
            m_led    = int'(bus.led_in);
            m_bright = int'(bus.bright_max);
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge osc_clk) begin
        if (gsrn) begin
            for (int i = 0; i < 4; i++) chk($sformatf("led_out[%0d]", i), int'(bus.led_out[i]), m_out[i]);
            chk("busy", int'(bus.busy), m_busy());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (lvl0_q.size() < n && k < 200) begin
            @(negedge osc_clk);
            k++;
        end
        if (lvl0_q.size() < n) chk("wait_level_timeout", lvl0_q.size(), n);
    endtask

    task automatic count_high(input int ch, output int cnt);
        cnt = 0;
        repeat (PERIOD) begin
            @(negedge osc_clk);
            cnt += int'(bus.led_out[ch]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c_on, c_off;
        int smp[32];
        bus.led_in = 4'b0000;
        bus.bright_max = '0;
        #1 gsrn = 1'b0;
        #1;
        chk("reset_led_out", int'(bus.led_out), 0);
        chk("reset_busy", int'(bus.busy), 0);

        // Rise with clamp: the level steps 3, 6, 9, then clamps at 10.
        bus.bright_max = 4'd10;
        bus.led_in = 4'b0001;
        cyc(2);
        #2 gsrn = 1'b1;
        lvl0_q.delete();
        wait_q(4);
        chk("rise_n", lvl0_q.size(), 4);
        chk("rise_l0", lvl0_q[0], 3);
        chk("rise_l1", lvl0_q[1], 6);
        chk("rise_l2", lvl0_q[2], 9);
        chk("rise_l3", lvl0_q[3], 10);
        cyc(20);
        chk("rise_busy_done", int'(bus.busy), 0);
        count_high(0, c);
        chk("rise_duty0", c, 10);
        c_off = 0;
        for (int i = 1; i < 4; i++) begin count_high(i, c); c_off += c; end
        chk("rise_others_dark", c_off, 0);

        // Fall to zero from full brightness.
        bus.bright_max = 4'd15;
        cyc(30);
        lvl0_q.delete();
        bus.led_in = 4'b0000;
        wait_q(5);
        cyc(20);
        chk("fall_n", lvl0_q.size(), 5);
        chk("fall_l0", lvl0_q[0], 12);
        chk("fall_l1", lvl0_q[1], 9);
        chk("fall_l2", lvl0_q[2], 6);
        chk("fall_l3", lvl0_q[3], 3);
        chk("fall_l4", lvl0_q[4], 0);
        count_high(0, c);
        chk("fall_dark", c, 0);
        chk("fall_busy", int'(bus.busy), 0);

        // Mid-ramp reversal at level 6.
        lvl0_q.delete();
        bus.led_in = 4'b0001;
        wait_q(2);
        bus.led_in = 4'b0000;
        chk("rev_busy_mid", int'(bus.busy), 1);
        cyc(30);
        chk("rev_n", lvl0_q.size(), 4);
        chk("rev_l2", lvl0_q[2], 3);
        chk("rev_l3", lvl0_q[3], 0);
        chk("rev_busy_end", int'(bus.busy), 0);

        // Brightness change with all channels on.
        bus.led_in = 4'b1111;
        cyc(30);
        lvl0_q.delete();
        bus.bright_max = 4'd4;
        cyc(30);
        chk("dim_n", lvl0_q.size(), 4);
        chk("dim_l0", lvl0_q[0], 12);
        chk("dim_l1", lvl0_q[1], 9);
        chk("dim_l2", lvl0_q[2], 6);
        chk("dim_l3", lvl0_q[3], 4);
        c_on = 0; c_off = 0;
        repeat (PERIOD) begin
            @(negedge osc_clk);
            if (bus.led_out == 4'hF) c_on++;
            if (bus.led_out == 4'h0) c_off++;
        end
        chk("dim_all_on", c_on, 4);
        chk("dim_all_off", c_off, 12);

        // Async reset in the middle of a ramp at level 9.
        bus.led_in = 4'b0000;
        cyc(20);
        lvl0_q.delete();
        bus.bright_max = 4'd15;
        bus.led_in = 4'b0001;
        wait_q(3);
        chk("rst_pre_level", lvl0_q[2], 9);
        chk("rst_pre_busy", int'(bus.busy), 1);
        #2 gsrn = 1'b0;
        #1;
        chk("rst_led_out", int'(bus.led_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        #1 gsrn = 1'b1;
        lvl0_q.delete();
        wait_q(1);
        chk("rst_restart_l0", lvl0_q[0], 3);

        // Wrap check: the pattern must repeat exactly every 16 cycles.
        cyc(40);
        for (int k = 0; k < 32; k++) begin
            @(negedge osc_clk);
            smp[k] = int'(bus.led_out[0]);
        end
        c = 0;
        for (int k = 0; k < 16; k++) c += smp[k];
        chk("wrap_duty", c, 15);
        for (int k = 0; k < 16; k++) chk($sformatf("wrap_rep[%0d]", k), smp[k + 16], smp[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
